// File: rtl/ir_pkg.sv
// Shared field map and constants for the 16-bit instruction register.
package ir_pkg;

  localparam int unsigned IR_W    = 16;
  localparam int unsigned FIELD_W = 4;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS_MSB  = 7;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned RT_MSB  = 3;
  localparam int unsigned RT_LSB  = 0;
  localparam int unsigned IMM_W   = 8;

  localparam logic [FIELD_W-1:0] OPC_HALT     = 4'hF;
  localparam logic [IR_W-1:0]    IR_RESET_VAL = 16'h0000;

  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] rt;
    logic [IR_W-1:0]    imm_sx;
    logic               is_halt;
  } ir_fields_t;

  function automatic ir_fields_t ir_split(input logic [IR_W-1:0] w);
    ir_fields_t f;
    f.opcode  = w[OPC_MSB:OPC_LSB];
    f.rd      = w[RD_MSB:RD_LSB];
    f.rs      = w[RS_MSB:RS_LSB];
    f.rt      = w[RT_MSB:RT_LSB];
    f.imm_sx  = {{(IR_W-IMM_W){w[IMM_W-1]}}, w[IMM_W-1:0]};
    f.is_halt = (w[OPC_MSB:OPC_LSB] == OPC_HALT);
    return f;
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational pre-decode of the held instruction word into its fields.
module ir_decode
  import ir_pkg::*;
(
  input  logic [IR_W-1:0]    d_out,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] rs,
  output logic [FIELD_W-1:0] rt,
  output logic [IR_W-1:0]    imm_sx,
  output logic               is_halt
);

  ir_fields_t fields;

  always_comb begin
    fields  = ir_split(d_out);
    opcode  = fields.opcode;
    rd      = fields.rd;
    rs      = fields.rs;
    rt      = fields.rt;
    imm_sx  = fields.imm_sx;
    is_halt = fields.is_halt;
  end

endmodule

// File: rtl/instr_reg.sv
// Instruction register with pre-decoded fields.
// Optional previous-word register enabled by defining IR_PREV_EN.
module instr_reg
  import ir_pkg::*;
#(
  parameter int unsigned     WIDTH     = IR_W,
  parameter logic [IR_W-1:0] RESET_VAL = IR_RESET_VAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c_e,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   d_out,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] rs,
  output logic [FIELD_W-1:0] rt,
  output logic [IR_W-1:0]    imm_sx,
  output logic               valid,
  output logic               is_halt,
  output logic [WIDTH-1:0]   d_prev
);

  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             valid_q, valid_d;

  always_comb begin
    d_out_d = d_out_q;
    valid_d = valid_q;
    if (c_e) begin
      d_out_d = d_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out_q <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      valid_q <= valid_d;
    end
  end

`ifdef IR_PREV_EN
  logic [WIDTH-1:0] prev_q, prev_d;

  // Old word is captured at the same edge the new one lands in d_out_q.
  always_comb begin
    prev_d = prev_q;
    if (c_e) prev_d = d_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= RESET_VAL;
    else      prev_q <= prev_d;
  end

  assign d_prev = prev_q;
`else
  assign d_prev = RESET_VAL;
`endif

  assign d_out = d_out_q;
  assign valid = valid_q;

  ir_decode u_decode (
    .d_out   (d_out_q),
    .opcode  (opcode),
    .rd      (rd),
    .rs      (rs),
    .rt      (rt),
    .imm_sx  (imm_sx),
    .is_halt (is_halt)
  );

endmodule

// File: tb/tb_instr_reg.sv
// Scoreboard bench for instr_reg: stimulus pushes expectations, monitor compares.
// Build with and without IR_PREV_EN; expectations follow the macro.
module tb_instr_reg;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_e = 1'b0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out, imm_sx, d_prev;
  logic [3:0]  opcode, rd, rs, rt;
  logic        valid, is_halt;

  instr_reg #(.WIDTH(16), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_e     (c_e),
    .d_in    (d_in),
    .d_out   (d_out),
    .opcode  (opcode),
    .rd      (rd),
    .rs      (rs),
    .rt      (rt),
    .imm_sx  (imm_sx),
    .valid   (valid),
    .is_halt (is_halt),
    .d_prev  (d_prev)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        valid;
    logic [15:0] prev;
  } exp_t;

  exp_t        sb_q[$];
  event        chk_ev;
  int          errors = 0;
  int          checks = 0;

  // Reference: list of words held since the last reset; the head is the reset value.
  logic [15:0] hist[$];

  function automatic exp_t model_now();
    exp_t e;
    e.word  = hist[hist.size()-1];
    e.valid = (hist.size() > 1);
`ifdef IR_PREV_EN
    e.prev  = (hist.size() > 1) ? hist[hist.size()-2] : RV;
`else
    e.prev  = RV;
`endif
    return e;
  endfunction

  function automatic void model_reset();
    hist.delete();
    hist.push_back(RV);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int unsigned w, opc, low;
    logic [15:0] x;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        w   = e.word;
        opc = w / 4096;
        low = w % 256;
        chk("d_out",   d_out, e.word);
        chk("valid",   {15'd0, valid}, {15'd0, e.valid});
        x = 16'(opc);           chk("opcode", {12'd0, opcode}, x);
        x = 16'((w / 256) % 16); chk("rd",     {12'd0, rd}, x);
        x = 16'((w / 16) % 16);  chk("rs",     {12'd0, rs}, x);
        x = 16'(w % 16);         chk("rt",     {12'd0, rt}, x);
        x = (low >= 128) ? 16'(low + 32'hFF00) : 16'(low);
        chk("imm_sx",  imm_sx, x);
        x = (opc == 15) ? 16'd1 : 16'd0;
        chk("is_halt", {15'd0, is_halt}, x);
        chk("d_prev",  d_prev, e.prev);
      end
    end
  end

  // Control input must be a clean 0/1 whenever the register is out of reset.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if ($isunknown(c_e)) begin
        errors++;
        $display("FAIL c_e_known: got %b expected 0/1 at t=%0t", c_e, $time);
      end
    end
  end

  task automatic cycle(input logic r, input logic ce, input logic [15:0] din);
    @(negedge clk);
    rst  = r;
    c_e  = ce;
    d_in = din;
    @(posedge clk);
    if (!r)      model_reset();
    else if (ce) hist.push_back(din);
    sb_q.push_back(model_now());
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    sb_q.push_back(model_now());
    ->chk_ev;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    model_reset();
    c_e  = 1'b1;
    d_in = 16'h00B1;
    #2;
    sb_q.push_back(model_now());
    ->chk_ev;

    cycle(1'b0, 1'b1, 16'h00B1);
    cycle(1'b0, 1'b1, 16'h00B1);
    cycle(1'b1, 1'b1, 16'h00B1);
    cycle(1'b1, 1'b1, 16'h1131);
    repeat (3) cycle(1'b1, 1'b0, 16'h8888);
    cycle(1'b1, 1'b1, 16'h80B1);
    cycle(1'b1, 1'b1, 16'hC0B1);
    cycle(1'b1, 1'b1, 16'hF000);
    mid_reset();
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 16'h1234);
    cycle(1'b1, 1'b1, 16'h7F80);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        mid_reset();
        cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      end else begin
        cycle(1'b1, ($urandom_range(0, 9) < 6), 16'($urandom));
      end
    end

    @(negedge clk);
    c_e = 1'b0;
    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
